// File: rtl/serial_ram_reader_if.sv
// Request/response port of the serial RAM read master.
// Master issues addresses and consumes read words; slave is the reader.
interface serial_ram_reader_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_BITS-1:0] req_addr;
    logic                 rsp_valid;
    logic [DATA_BITS-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/serial_ram_reader.sv
// Pin-serial RAM read master: shifts addresses out in fixed frames and
// reassembles the returning data stream into one-cycle response pulses.
module serial_ram_reader #(
    parameter int ADDR_PINS   = 4,
    parameter int DATA_PINS   = 4,
    parameter int LOG2_CYCLES = 2,
    parameter int LATENCY     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_ram_reader_if.slave   bus,
    output logic [ADDR_PINS-1:0] addr_out,
    input  logic [DATA_PINS-1:0] data_in
);
    localparam int CYCLES    = 1 << LOG2_CYCLES;
    localparam int ADDR_BITS = ADDR_PINS * CYCLES;
    localparam int DATA_BITS = DATA_PINS * CYCLES;
    localparam int DEPTH     = LATENCY + CYCLES;
    localparam logic [LOG2_CYCLES-1:0] PH_LAST = '1;

    logic [LOG2_CYCLES-1:0]             phase;
    logic                               last_phase;
    logic                               pending;
    logic [ADDR_BITS-1:0]               pend_addr;
    logic                               fire;
    logic                               launch;
    logic [ADDR_BITS-1:0]               launch_addr;
    logic [CYCLES-1:0][ADDR_PINS-1:0]   frame_addr;
    logic [DEPTH-1:0]                   tag;
    logic [DATA_BITS-1:0]               acc;
    logic [DATA_BITS-1:0]               rsp_data_q;
    logic                               rsp_valid_q;

    assign last_phase    = (phase == PH_LAST);
    assign bus.req_ready = !pending && !reset;
    assign fire          = bus.req_valid && bus.req_ready;

    // Pending address wins the slot; otherwise a same-cycle request bypasses.
    always_comb begin
        launch      = 1'b0;
        launch_addr = '0;
        if (last_phase) begin
            unique case (1'b1)
                pending: begin
                    launch      = 1'b1;
                    launch_addr = pend_addr;
                end
                fire: begin
                    launch      = 1'b1;
                    launch_addr = bus.req_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= '0;
            pending     <= 1'b0;
            pend_addr   <= '0;
            frame_addr  <= '0;
            tag         <= '0;
            acc         <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            phase <= phase + LOG2_CYCLES'(1);
            if (last_phase) begin
                frame_addr <= launch_addr;
            end
            if (last_phase && pending) begin
                pending <= 1'b0;
            end else if (fire && !last_phase) begin
                pending   <= 1'b1;
                pend_addr <= bus.req_addr;
            end
            // tag[d] marks cycle T0+d of a frame carrying a real read
            tag <= {tag[DEPTH-2:0], launch};
            acc <= {data_in, acc[DATA_BITS-1:DATA_PINS]};
            if (tag[DEPTH-1]) begin
                rsp_data_q <= {data_in, acc[DATA_BITS-1:DATA_PINS]};
            end
            rsp_valid_q <= tag[DEPTH-1];
        end
    end

    assign addr_out      = reset ? '0 : frame_addr[phase];
    assign bus.rsp_valid = rsp_valid_q && !reset;
    assign bus.rsp_data  = reset ? '0 : rsp_data_q;
endmodule

// File: tb/tb_serial_ram_reader.sv
// Directed bench for serial_ram_reader against a one-stage serial RAM model.
// Responses are checked against a scoreboard filled at request acceptance.
module tb_serial_ram_reader;
    logic        clk;
    logic        reset;
    logic [3:0]  addr_out;
    logic [3:0]  data_in;

    serial_ram_reader_if #(.ADDR_BITS(16), .DATA_BITS(16)) bus ();

    serial_ram_reader #(
        .ADDR_PINS(4), .DATA_PINS(4), .LOG2_CYCLES(2), .LATENCY(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .addr_out(addr_out),
        .data_in(data_in)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [4096];
    logic [3:0]  sched [16];
    logic [1:0]  ph;
    logic [15:0] ram_addr;
    logic [15:0] w;
    int          cyc;

    logic [15:0] exp_q [$];
    int          rsp_cyc_q [$];
    int          rsp_cnt;
    int          last_rsp;
    logic [15:0] last_data;
    int          acc_cyc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Serial RAM model: one output delay stage, low 12 address bits.
    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'(a) ^ 16'h5A5A;
        mem[12'hFFF] = 16'hA5A5;
        for (int i = 0; i < 16; i++) sched[i] = 4'h0;
        ram_addr = '0;
        w = '0;
    end

    initial begin
        ph = '0;
        cyc = 0;
        data_in = '0;
    end

    always @(posedge clk) begin
        if (reset) begin
            ph <= '0;
            ram_addr = '0;
        end else begin
            ram_addr[ph*4 +: 4] = addr_out;
            if (ph == 2'd3) begin
                w = mem[ram_addr[11:0]];
                for (int j = 0; j < 4; j++)
                    sched[(cyc + 3 + j) % 16] = w[j*4 +: 4];
            end
            ph <= ph + 2'd1;
        end
        data_in <= sched[(cyc + 1) % 16];
        cyc <= cyc + 1;
    end

    initial begin
        rsp_cnt = 0;
        last_rsp = 0;
        last_data = '0;
        acc_cyc = 0;
    end

    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            rsp_cnt++;
            last_rsp = cyc;
            last_data = bus.rsp_data;
            rsp_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) check("rsp_extra", 1, 0);
            else check("rsp_data", bus.rsp_data, exp_q.pop_front());
        end
        if (!reset && bus.req_valid && bus.req_ready) begin
            exp_q.push_back(mem[bus.req_addr[11:0]]);
            acc_cyc = cyc;
        end
    end

    task automatic send(input logic [15:0] a);
        bit done;
        done = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic to_phase(input logic [1:0] p);
        for (int i = 0; i < 8 && ph != p; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rsp(input int target, input int bound);
        for (int i = 0; i < bound && rsp_cnt < target; i++) @(posedge clk);
        #1;
        if (rsp_cnt < target) check("rsp_timeout", 0, 1);
    endtask

    initial begin
        int base;
        int t_acc;
        int t_first;
        int bad;

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", bus.req_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_addr_out", addr_out, 0);
        check("reset_rsp_data", bus.rsp_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single read accepted at phase 3
        to_phase(2'd3);
        base = rsp_cnt;
        send(16'h0123);
        t_acc = acc_cyc;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("single_addr_chunk", addr_out, 32'(3 - k));
        end
        wait_rsp(base + 1, 40);
        check("single_latency", last_rsp - t_acc, 11);
        check("single_data", last_data, 16'h5B79);

        // Back-to-back reads
        base = rsp_cnt;
        rsp_cyc_q.delete();
        for (int i = 0; i < 8; i++) send(16'(i));
        wait_rsp(base + 8, 200);
        for (int i = 1; i < 8 && i < rsp_cyc_q.size(); i++)
            check("b2b_spacing", rsp_cyc_q[i] - rsp_cyc_q[i-1], 4);
        repeat (20) @(posedge clk);
        check("b2b_count", rsp_cnt - base, 8);

        // Holding register: phase-0 request stalls a phase-1 request
        to_phase(2'd0);
        base = rsp_cnt;
        send(16'h0040);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0041;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_stall", bus.req_ready, 0);
        end
        @(negedge clk);
        check("hold_release", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_rsp(base + 2, 60);

        // Idle frames stay quiet
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (addr_out != 4'h0 || bus.rsp_valid) bad++;
        end
        check("idle_quiet", bad, 0);

        // One idle frame between two reads
        base = rsp_cnt;
        to_phase(2'd3);
        send(16'h0100);
        repeat (4) @(posedge clk);
        #1;
        to_phase(2'd3);
        send(16'h0101);
        wait_rsp(base + 1, 40);
        t_first = last_rsp;
        wait_rsp(base + 2, 40);
        check("gap_spacing", last_rsp - t_first, 8);

        // Reset in the middle of a read
        to_phase(2'd3);
        send(16'h00FF);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midreset_rsp_data", bus.rsp_data, 0);
        check("midreset_ready", bus.req_ready, 0);
        check("midreset_addr_out", addr_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        base = rsp_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("midreset_drop", rsp_cnt - base, 0);
        send(16'h0010);
        wait_rsp(base + 1, 40);
        check("post_reset_data", last_data, 16'h5A4A);

        // Address wrap past the RAM's 12-bit space
        base = rsp_cnt;
        send(16'hFFFF);
        wait_rsp(base + 1, 40);
        check("wrap_data", last_data, 16'hA5A5);

        repeat (20) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
